// File: rtl/clk_div_ctrl.sv
// Ratio-change sequencer for the even clock divider.
// Arbitrates two requesters round-robin, rejects odd ratios, and performs a
// glitch-free change: disable, drain one old period, load, re-enable, settle, ack.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for a request; grants and decides the sequence
// ST_DRAIN  | divider disabled, waiting div_n cycles of the old ratio
// ST_LOAD   | one cycle: new ratio applied, enable restored if ratio != 0
// ST_SETTLE | divider running at the new ratio, waiting SETTLE cycles
// ST_ACK    | one cycle: ack (and err) to the granted requester
module clk_div_ctrl #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] n0,
    input  logic             req1,
    input  logic [WIDTH-1:0] n1,
    output logic             ack0,
    output logic             ack1,
    output logic             err,
    output logic             busy,
    output logic [WIDTH-1:0] div_n,
    output logic             div_en
);

    localparam int SCW = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_LOAD,
        ST_SETTLE,
        ST_ACK
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pend_n;
    logic [WIDTH-1:0] drain_cnt;
    logic [SCW-1:0]   settle_cnt;
    logic             gnt_id;
    logic             rr_ptr;

    logic             gnt_valid;
    logic             gnt_sel;
    logic [WIDTH-1:0] req_n;

    // Pick the requester to serve: sole requester wins, ties go to rr_ptr
    always_comb begin
        gnt_valid = req0 | req1;
        gnt_sel   = (req0 & req1) ? rr_ptr : req1;
        req_n     = gnt_sel ? n1 : n0;
    end

    // Sequencer; all outputs are registered and set on entry to each state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            pend_n     <= '0;
            drain_cnt  <= '0;
            settle_cnt <= '0;
            gnt_id     <= 1'b0;
            rr_ptr     <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            div_n      <= '0;
            div_en     <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        pend_n <= req_n;
                        gnt_id <= gnt_sel;
                        rr_ptr <= ~gnt_sel;
                        busy   <= 1'b1;
                        // Odd ratios (including 1) cannot be produced by an even divider
                        if (req_n[0]) begin
                            state <= ST_ACK;
                            ack0  <= ~gnt_sel;
                            ack1  <= gnt_sel;
                            err   <= 1'b1;
                        end else if (div_en && (req_n == div_n)) begin
                            state <= ST_ACK;
                            ack0  <= ~gnt_sel;
                            ack1  <= gnt_sel;
                        end else if (div_en) begin
                            state     <= ST_DRAIN;
                            div_en    <= 1'b0;
                            drain_cnt <= div_n;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt <= WIDTH'(1)) begin
                        state <= ST_LOAD;
                    end else begin
                        drain_cnt <= drain_cnt - WIDTH'(1);
                    end
                end
                ST_LOAD: begin
                    div_n <= pend_n;
                    // A zero ratio is a request to leave the divider disabled
                    if (pend_n == '0) begin
                        state <= ST_ACK;
                        ack0  <= ~gnt_id;
                        ack1  <= gnt_id;
                    end else begin
                        state      <= ST_SETTLE;
                        div_en     <= 1'b1;
                        settle_cnt <= SCW'(SETTLE);
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt <= SCW'(1)) begin
                        state <= ST_ACK;
                        ack0  <= ~gnt_id;
                        ack1  <= gnt_id;
                    end else begin
                        settle_cnt <= settle_cnt - SCW'(1);
                    end
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed table, hand sequences for arbitration and
// reset abort, then randomized requests against a transaction-level model.
module tb_clk_div_ctrl;

    localparam int W     = 8;
    localparam int SET   = 4;
    localparam int BOUND = 400;

    logic         clk;
    logic         reset_n;
    logic         req0, req1;
    logic [W-1:0] n0, n1;
    logic         ack0, ack1, err, busy, div_en;
    logic [W-1:0] div_n;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: current ratio/enable and round-robin pointer
    logic [W-1:0] m_n;
    bit           m_en;
    bit           m_ptr;

    clk_div_ctrl #(.WIDTH(W), .SETTLE(SET)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .req0   (req0),
        .n0     (n0),
        .req1   (req1),
        .n1     (n1),
        .ack0   (ack0),
        .ack1   (ack1),
        .err    (err),
        .busy   (busy),
        .div_n  (div_n),
        .div_en (div_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Expected outcome of one granted request, from the latency rules
    function automatic void model_txn(input logic [W-1:0] cn, input bit cen, input logic [W-1:0] rn,
                                      output int lat, output bit e, output logic [W-1:0] nn,
                                      output bit nen, output bit en1);
        int drain;
        nn  = cn;
        nen = cen;
        e   = 1'b0;
        en1 = 1'b0;
        if (rn % 2 == 1) begin
            lat = 1;
            e   = 1'b1;
            en1 = cen;
        end else if (cen && rn == cn) begin
            lat = 1;
            en1 = cen;
        end else begin
            drain = cen ? int'(cn) : 0;
            nn    = rn;
            nen   = (rn != 0);
            lat   = drain + 2 + ((rn != 0) ? SET : 0);
        end
    endfunction

    // Wait for an ack; lat=0 signals timeout
    task automatic wait_ack(output int lat, output bit id, output bit e, output bit en1);
        lat = 0;
        id  = 1'b0;
        e   = 1'b0;
        en1 = 1'b0;
        for (int k = 1; k <= BOUND; k++) begin
            @(negedge clk);
            if (k == 1) en1 = div_en;
            check("ack_exclusive", {31'd0, ack0 & ack1}, 32'd0);
            check("err_needs_ack", {31'd0, err & ~(ack0 | ack1)}, 32'd0);
            check("busy_in_seq", {31'd0, busy}, 32'd1);
            if (ack0 | ack1) begin
                lat = k;
                id  = ack1;
                e   = err;
                break;
            end
        end
        if (lat == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_timeout: got no ack within %0d cycles, required an ack", BOUND);
        end
    endtask

    // Serve requests already driven on req0/req1, checking each against the model
    task automatic serve_loop(input bit p0, input bit p1, input logic [W-1:0] a0, input logic [W-1:0] a1);
        bit pend0, pend1, exp_id, id, e, en1, eerr, nen, een1;
        int lat, elat;
        logic [W-1:0] rn, nn;
        pend0 = p0;
        pend1 = p1;
        while (pend0 || pend1) begin
            exp_id = (pend0 && pend1) ? m_ptr : pend1;
            rn     = exp_id ? a1 : a0;
            model_txn(m_n, m_en, rn, elat, eerr, nn, nen, een1);
            wait_ack(lat, id, e, en1);
            if (lat == 0) begin
                req0 = 1'b0;
                req1 = 1'b0;
                pend0 = 1'b0;
                pend1 = 1'b0;
                @(negedge clk);
            end else begin
                check("grant_id", {31'd0, id}, {31'd0, exp_id});
                check("latency", lat, elat);
                check("err", {31'd0, e}, {31'd0, eerr});
                check("div_en_t1", {31'd0, en1}, {31'd0, een1});
                check("div_n", {24'd0, div_n}, {24'd0, nn});
                check("div_en", {31'd0, div_en}, {31'd0, nen});
                m_n   = nn;
                m_en  = nen;
                m_ptr = ~exp_id;
                if (id) begin req1 = 1'b0; pend1 = 1'b0; end
                else    begin req0 = 1'b0; pend0 = 1'b0; end
                @(negedge clk);
                check("busy_after_ack", {31'd0, busy}, 32'd0);
            end
        end
    endtask

    task automatic serve(input bit r0, input bit r1, input logic [W-1:0] a0, input logic [W-1:0] a1);
        req0 = r0;
        n0   = a0;
        req1 = r1;
        n1   = a1;
        serve_loop(r0, r1, a0, a1);
    endtask

    function automatic logic [W-1:0] pick_n();
        case ($urandom_range(0, 3))
            0:       return W'($urandom_range(0, 127) * 2 + 1);
            1:       return '0;
            2:       return m_n;
            default: return W'($urandom_range(1, 20) * 2);
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_n   = '0;
        m_en  = 1'b0;
        m_ptr = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        bit           id;
        logic [W-1:0] n;
        int           lat;
        bit           err;
        logic [W-1:0] dn;
        bit           den;
        bit           en1;
    } vec_t;

    vec_t tbl[11];

    initial begin
        bit id, e, en1;
        int lat;
        logic [W-1:0] a, b;

        tbl[0]  = '{1'b0, 8'd8,   6,  1'b0, 8'd8,   1'b1, 1'b0};
        tbl[1]  = '{1'b1, 8'd4,   14, 1'b0, 8'd4,   1'b1, 1'b0};
        tbl[2]  = '{1'b0, 8'd5,   1,  1'b1, 8'd4,   1'b1, 1'b1};
        tbl[3]  = '{1'b0, 8'd1,   1,  1'b1, 8'd4,   1'b1, 1'b1};
        tbl[4]  = '{1'b0, 8'd4,   1,  1'b0, 8'd4,   1'b1, 1'b1};
        tbl[5]  = '{1'b1, 8'd6,   10, 1'b0, 8'd6,   1'b1, 1'b0};
        tbl[6]  = '{1'b0, 8'd0,   8,  1'b0, 8'd0,   1'b0, 1'b0};
        tbl[7]  = '{1'b1, 8'd0,   2,  1'b0, 8'd0,   1'b0, 1'b0};
        tbl[8]  = '{1'b1, 8'd2,   6,  1'b0, 8'd2,   1'b1, 1'b0};
        tbl[9]  = '{1'b0, 8'd254, 8,  1'b0, 8'd254, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 8'd254, 1,  1'b0, 8'd254, 1'b1, 1'b1};

        reset_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        n0 = '0;
        n1 = '0;
        repeat (3) @(negedge clk);
        check("rst_div_n", {24'd0, div_n}, 32'd0);
        check("rst_div_en", {31'd0, div_en}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_acks", {30'd0, ack1, ack0}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed table, one requester at a time
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].id) begin req1 = 1'b1; n1 = tbl[i].n; end
            else           begin req0 = 1'b1; n0 = tbl[i].n; end
            wait_ack(lat, id, e, en1);
            check($sformatf("tbl%0d_id", i), {31'd0, id}, {31'd0, tbl[i].id});
            check($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
            check($sformatf("tbl%0d_err", i), {31'd0, e}, {31'd0, tbl[i].err});
            check($sformatf("tbl%0d_en_t1", i), {31'd0, en1}, {31'd0, tbl[i].en1});
            check($sformatf("tbl%0d_div_n", i), {24'd0, div_n}, {24'd0, tbl[i].dn});
            check($sformatf("tbl%0d_div_en", i), {31'd0, div_en}, {31'd0, tbl[i].den});
            req0 = 1'b0;
            req1 = 1'b0;
            @(negedge clk);
            check($sformatf("tbl%0d_busy_idle", i), {31'd0, busy}, 32'd0);
        end

        // Simultaneous requests after reset, then alternation of the tie-break
        do_reset();
        serve(1'b1, 1'b1, 8'd8, 8'd4);
        serve(1'b1, 1'b0, 8'd5, 8'd0);
        serve(1'b1, 1'b1, 8'd6, 8'd2);

        // Reset in the middle of DRAIN with both requests held
        req0 = 1'b1;
        n0   = 8'd4;
        @(negedge clk);
        req1 = 1'b1;
        n1   = 8'd2;
        repeat (2) @(negedge clk);
        check("drain_busy", {31'd0, busy}, 32'd1);
        check("drain_div_en", {31'd0, div_en}, 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("abort_div_en", {31'd0, div_en}, 32'd0);
        check("abort_div_n", {24'd0, div_n}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_acks", {30'd0, ack1, ack0}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("abort_no_ack", {30'd0, ack1, ack0}, 32'd0);
        end
        reset_n = 1'b1;
        m_n   = '0;
        m_en  = 1'b0;
        m_ptr = 1'b0;
        serve_loop(1'b1, 1'b1, 8'd4, 8'd2);

        // Randomized requests against the model
        for (int i = 0; i < 40; i++) begin
            a = pick_n();
            b = pick_n();
            case ($urandom_range(0, 2))
                0:       serve(1'b1, 1'b0, a, b);
                1:       serve(1'b0, 1'b1, a, b);
                default: serve(1'b1, 1'b1, a, b);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
